// File: rtl/uart_pkg.sv
// Shared definitions for the UART CPU-side bus master: FSM states,
// C_nD encodings and default cycle timings.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  localparam logic C_DATA = 1'b0;
  localparam logic C_CTRL = 1'b1;

  localparam int unsigned DEF_SETUP_CYC   = 1;
  localparam int unsigned DEF_STROBE_CYC  = 2;
  localparam int unsigned DEF_HOLD_CYC    = 1;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/uart_cpu_timer.sv
// Loadable down-counter that stops at zero; o_zero flags the final cycle of a
// state whose dwell time was loaded as (cycles - 1).
module uart_cpu_timer #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_n_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/uart_cpu_master.sv
// Bus initiator for the UART CPU port: turns valid/ready commands into timed
// read/write cycles, optionally gated on Tx_RDY/Rx_RDY with a timeout.
module uart_cpu_master
  import uart_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       n_RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_cd,
  input  logic       cmd_wait,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       C_nD,
  output logic       n_RD,
  output logic       n_WR,
  output logic       n_CS,
  output logic [7:0] DATA_OUT,
  input  logic [7:0] DATA_IN,
  input  logic       Tx_RDY,
  input  logic       Rx_RDY
);

  localparam int unsigned MAXC = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TIMEOUT_CYC);
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  state_t          r_state, w_state_nxt;
  logic            w_accept, w_zero, w_load;
  logic [CW-1:0]   w_load_val;
  logic            r_cmd_write, r_cmd_cd;
  logic [7:0]      r_cmd_wdata;
  logic            w_write, w_cd;
  logic [7:0]      w_wdata;
  logic            r_ready, r_rsp_valid, r_rsp_err;
  logic [7:0]      r_rsp_rdata;
  logic            r_cnd, r_nrd, r_nwr, r_ncs;
  logic [7:0]      r_dout;

  assign w_accept = cmd_valid && r_ready;

  // Entering SETUP straight from IDLE happens on the accept edge, before the
  // command registers hold the new command.
  assign w_write = (r_state == ST_IDLE) ? cmd_write : r_cmd_write;
  assign w_cd    = (r_state == ST_IDLE) ? cmd_cd    : r_cmd_cd;
  assign w_wdata = (r_state == ST_IDLE) ? cmd_wdata : r_cmd_wdata;

  uart_cpu_timer #(.W(CW)) u_timer (
    .i_clk   (clk),
    .i_n_rst (n_RST),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE:
        if (w_accept)
          w_state_nxt = (cmd_wait && (cmd_cd == C_DATA)) ? ST_WAIT_RDY : ST_SETUP;
      ST_WAIT_RDY:
        if (r_cmd_write ? Tx_RDY : Rx_RDY) w_state_nxt = ST_SETUP;
        else if (w_zero)                   w_state_nxt = ST_RESP;
      ST_SETUP:  if (w_zero) w_state_nxt = ST_STROBE;
      ST_STROBE: if (w_zero) w_state_nxt = ST_HOLD;
      ST_HOLD:   if (w_zero) w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    w_load = (w_state_nxt != r_state);
    case (w_state_nxt)
      ST_WAIT_RDY: w_load_val = CW'(TIMEOUT_CYC - 1);
      ST_SETUP:    w_load_val = CW'(SETUP_CYC - 1);
      ST_STROBE:   w_load_val = CW'(STROBE_CYC - 1);
      ST_HOLD:     w_load_val = CW'(HOLD_CYC - 1);
      default:     w_load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_cmd_write <= 1'b0;
      r_cmd_cd    <= C_CTRL;
      r_cmd_wdata <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_ncs       <= 1'b1;
      r_nrd       <= 1'b1;
      r_nwr       <= 1'b1;
      r_cnd       <= C_CTRL;
      r_dout      <= '0;
    end else begin
      if (w_accept) begin
        r_cmd_write <= cmd_write;
        r_cmd_cd    <= cmd_cd;
        r_cmd_wdata <= cmd_wdata;
      end
      r_ready     <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_rsp_err   <= (w_state_nxt == ST_RESP) && (r_state == ST_WAIT_RDY);
      r_ncs       <= !(w_state_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD});
      r_nwr       <= !((w_state_nxt == ST_STROBE) && r_cmd_write);
      r_nrd       <= !((w_state_nxt == ST_STROBE) && !r_cmd_write);
      if ((w_state_nxt == ST_SETUP) && (r_state != ST_SETUP)) begin
        r_cnd  <= w_cd;
        r_dout <= w_write ? w_wdata : '0;
      end else if (w_state_nxt == ST_RESP) begin
        r_cnd  <= C_CTRL;
        r_dout <= '0;
      end
      // Read data is taken on the edge at which the strobe rises.
      if ((r_state == ST_STROBE) && w_zero && !r_cmd_write)
        r_rsp_rdata <= DATA_IN;
      else if ((w_state_nxt == ST_RESP) && (r_state != ST_RESP) &&
               (r_cmd_write || (r_state == ST_WAIT_RDY)))
        r_rsp_rdata <= '0;
    end
  end

  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign n_CS      = r_ncs;
  assign n_RD      = r_nrd;
  assign n_WR      = r_nwr;
  assign C_nD      = r_cnd;
  assign DATA_OUT  = r_dout;

endmodule

// File: tb/tb_uart_cpu_master.sv
// Self-checking bench for uart_cpu_master: directed table, randomized commands
// against a transaction-level model, and a reset-during-strobe sequence.
module tb_uart_cpu_master;

  localparam int S_C   = 1;
  localparam int ST_C  = 2;
  localparam int H_C   = 1;
  localparam int TO_C  = 16;
  localparam logic [7:0] STATUS = 8'h05;

  logic       clk = 1'b0;
  logic       n_RST = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic       cmd_write = 1'b0, cmd_cd = 1'b0, cmd_wait = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       C_nD, n_RD, n_WR, n_CS;
  logic [7:0] DATA_OUT, DATA_IN;
  logic       Tx_RDY, Rx_RDY;

  always #5 clk = ~clk;

  uart_cpu_master #(
    .SETUP_CYC  (S_C),
    .STROBE_CYC (ST_C),
    .HOLD_CYC   (H_C),
    .TIMEOUT_CYC(TO_C)
  ) dut (
    .clk(clk), .n_RST(n_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_cd(cmd_cd), .cmd_wait(cmd_wait), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .C_nD(C_nD), .n_RD(n_RD), .n_WR(n_WR), .n_CS(n_CS),
    .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .Tx_RDY(Tx_RDY), .Rx_RDY(Rx_RDY)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART model with TxD looped to RxD: data writes enter a 16-deep FIFO,
  // data reads pop it, control/status reads return a fixed status byte.
  logic [7:0] fifo [16];
  logic [3:0] f_rp = '0, f_wp = '0;
  int         f_cnt = 0;
  logic       tx_gate = 1'b0, rx_gate = 1'b0;
  logic       p_wr = 1'b1, p_rd = 1'b1, p_cs = 1'b1;
  int         inv_err = 0;
  int         win_cnt = 0;

  assign Tx_RDY  = tx_gate;
  assign Rx_RDY  = rx_gate && (f_cnt != 0);
  assign DATA_IN = C_nD ? STATUS : ((f_cnt != 0) ? fifo[f_rp] : 8'h00);

  always @(negedge clk) begin
    if (!n_RST) begin
      f_rp  <= '0;
      f_wp  <= '0;
      f_cnt <= 0;
    end else if (!p_wr && n_WR && !C_nD && f_cnt < 16) begin
      fifo[f_wp] <= DATA_OUT;
      f_wp  <= f_wp + 4'd1;
      f_cnt <= f_cnt + 1;
    end else if (!p_rd && n_RD && !C_nD && f_cnt > 0) begin
      f_rp  <= f_rp + 4'd1;
      f_cnt <= f_cnt - 1;
    end
    if ((!n_RD && !n_WR) || (n_CS && (!n_RD || !n_WR))) inv_err <= inv_err + 1;
    if (p_cs && !n_CS) win_cnt <= win_cnt + 1;
    p_wr <= n_WR;
    p_rd <= n_RD;
    p_cs <= n_CS;
  end

  typedef struct {
    bit         wr;
    bit         cd;
    bit         wt;
    logic [7:0] wdata;
    int         delay;
    bit         stuck;
    int         exp_lat;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  logic [7:0] mq[$];
  int exp_win = 0;

  // Transaction-level prediction: waiting only for data cycles, flag seen
  // after 'delay' idle wait cycles unless stuck or the RX FIFO is empty.
  task automatic predict(inout vec_t v);
    bit waits, flag_ok;
    waits   = v.wt && !v.cd;
    flag_ok = v.wr ? !v.stuck : (!v.stuck && mq.size() > 0);
    if (waits && !(flag_ok && v.delay < TO_C)) begin
      v.exp_err   = 1'b1;
      v.exp_lat   = TO_C + 1;
      v.exp_rdata = 8'h00;
    end else begin
      v.exp_err = 1'b0;
      v.exp_lat = (waits ? v.delay + 2 : 1) + S_C + ST_C + H_C;
      if (v.wr) begin
        v.exp_rdata = 8'h00;
        if (!v.cd && mq.size() < 16) mq.push_back(v.wdata);
      end else if (v.cd) begin
        v.exp_rdata = STATUS;
      end else if (mq.size() > 0) begin
        v.exp_rdata = mq.pop_front();
      end else begin
        v.exp_rdata = 8'h00;
      end
    end
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int n, lat, wr_low, rd_low, cs_low, cs_fall, win_bad;
    bit got, waits, perform;
    logic err;
    logic [7:0] rd, exp_dout;
    waits    = v.wt && !v.cd;
    perform  = !v.exp_err;
    exp_dout = v.wr ? v.wdata : 8'h00;
    cmd_write = v.wr; cmd_cd = v.cd; cmd_wait = v.wt; cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; lat = -1; wr_low = 0; rd_low = 0; cs_low = 0; cs_fall = -1; win_bad = 0;
    got = 1'b0; err = 1'b0; rd = 8'h00;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      tx_gate = (n > v.delay) && !v.stuck;
      rx_gate = (n > v.delay) && !v.stuck;
      if (!n_CS) begin
        cs_low++;
        if (cs_fall < 0) cs_fall = n;
        if (C_nD !== v.cd || DATA_OUT !== exp_dout) win_bad++;
      end
      if (!n_WR) wr_low++;
      if (!n_RD) rd_low++;
      if (rsp_valid) begin
        got = 1'b1;
        lat = n;
        err = rsp_err;
        rd  = rsp_rdata;
        chk({tag, "_ready_in_resp"}, {31'd0, cmd_ready}, 32'd0);
      end
    end
    tx_gate = 1'b0;
    rx_gate = 1'b0;
    if (perform) exp_win++;
    chk({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({tag, "_rdata"}, {24'd0, rd}, {24'd0, v.exp_rdata});
    chk({tag, "_nwr_cycles"}, wr_low, (perform && v.wr) ? ST_C : 0);
    chk({tag, "_nrd_cycles"}, rd_low, (perform && !v.wr) ? ST_C : 0);
    chk({tag, "_ncs_cycles"}, cs_low, perform ? S_C + ST_C + H_C : 0);
    chk({tag, "_ncs_fall"}, cs_fall, perform ? (waits ? v.delay + 2 : 1) : -1);
    chk({tag, "_bus_stable"}, win_bad, 0);
  endtask

  vec_t tbl[14];

  initial begin
    vec_t v;
    int n, bad;

    tbl[0]  = '{1, 1, 0, 8'h4E, 0,  0, 5,  0, 8'h00};
    tbl[1]  = '{0, 1, 0, 8'h00, 0,  0, 5,  0, 8'h05};
    tbl[2]  = '{1, 0, 1, 8'hA5, 10, 0, 16, 0, 8'h00};
    tbl[3]  = '{0, 0, 1, 8'h00, 0,  0, 6,  0, 8'hA5};
    tbl[4]  = '{0, 0, 1, 8'h00, 0,  1, 17, 1, 8'h00};
    tbl[5]  = '{1, 1, 0, 8'h37, 0,  0, 5,  0, 8'h00};
    tbl[6]  = '{1, 0, 0, 8'h3C, 0,  0, 5,  0, 8'h00};
    tbl[7]  = '{0, 0, 1, 8'h00, 3,  0, 9,  0, 8'h3C};
    tbl[8]  = '{1, 1, 1, 8'h81, 0,  1, 5,  0, 8'h00};
    tbl[9]  = '{1, 0, 1, 8'h9C, 15, 0, 21, 0, 8'h00};
    tbl[10] = '{1, 0, 1, 8'h77, 16, 0, 17, 1, 8'h00};
    tbl[11] = '{0, 0, 0, 8'h00, 0,  0, 5,  0, 8'h9C};
    tbl[12] = '{0, 0, 0, 8'h00, 0,  0, 5,  0, 8'h00};
    tbl[13] = '{0, 1, 1, 8'h00, 0,  1, 5,  0, 8'h05};

    #1 n_RST = 1'b0;
    @(negedge clk);
    chk("rst_ncs", {31'd0, n_CS}, 32'd1);
    chk("rst_nrd", {31'd0, n_RD}, 32'd1);
    chk("rst_nwr", {31'd0, n_WR}, 32'd1);
    chk("rst_cnd", {31'd0, C_nD}, 32'd1);
    chk("rst_dout", {24'd0, DATA_OUT}, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, cmd_ready}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    n_RST = 1'b1;
    #1 chk("ready_at_release", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      v = tbl[i];
      predict(v);
      run_cmd(tbl[i], $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.cd    = ($urandom_range(0, 3) == 0);
      v.wt    = 1'($urandom_range(0, 1));
      v.wdata = 8'($urandom);
      v.delay = int'($urandom_range(0, 18));
      v.stuck = ($urandom_range(0, 7) == 0);
      predict(v);
      run_cmd(v, $sformatf("rnd%0d", i));
    end

    // Reset asserted while n_WR is low.
    cmd_write = 1'b1; cmd_cd = 1'b0; cmd_wait = 1'b0; cmd_wdata = 8'h5A;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (n_WR && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_strobe_reached", {31'd0, n_WR}, 32'd0);
    exp_win++;
    #2 n_RST = 1'b0;
    #1;
    chk("mid_rst_nwr", {31'd0, n_WR}, 32'd1);
    chk("mid_rst_ncs", {31'd0, n_CS}, 32'd1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid || cmd_ready) bad++;
    end
    n_RST = 1'b1;
    mq.delete();
    @(posedge clk);
    #1 chk("mid_rst_ready_after", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("mid_rst_no_rsp", bad, 0);

    v = '{1, 0, 0, 8'hC3, 0, 0, 0, 0, 8'h00};
    predict(v);
    run_cmd(v, "post_rst_wr");
    v = '{0, 0, 1, 8'h00, 2, 0, 0, 0, 8'h00};
    predict(v);
    run_cmd(v, "post_rst_rd");

    @(negedge clk);
    chk("bus_invariants", inv_err, 0);
    chk("ncs_windows", win_cnt, exp_win);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cpu_master.md
Name: uart_cpu_master

Overview:
- Bus initiator that drives the UART's CPU-side interface (C_nD / n_RD / n_WR / n_CS / 8-bit data).
- Turns a simple valid/ready command stream into correctly timed read and write cycles.
- Optionally waits on Tx_RDY / Rx_RDY before data transfers, with a timeout.
- Sits between a test sequencer or soft controller and the UART, and is used to program control words, push TX characters, poll status and pop RX characters.

Parameters:
- SETUP_CYC, 1, cycles that n_CS, C_nD and write data are stable before the strobe falls (≥1).
- STROBE_CYC, 2, cycles n_RD or n_WR is held low (≥1).
- HOLD_CYC, 1, cycles n_CS, C_nD and write data stay stable after the strobe rises (≥1).
- TIMEOUT_CYC, 1024, maximum cycles spent waiting for a ready flag before giving up with an error.

Ports:
- clk  in  1  system clock.
- n_RST  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write cycle, 0 = read cycle.
- cmd_cd  in  1  value driven on C_nD (0 = data, 1 = control/status).
- cmd_wait  in  1  1 = gate the transfer on the UART ready flag.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse marking a completed command.
- rsp_rdata  out  8  read data (0 for writes).
- rsp_err  out  1  ready-wait timed out; no bus cycle was issued.
- C_nD  out  1  to UART.
- n_RD  out  1  to UART.
- n_WR  out  1  to UART.
- n_CS  out  1  to UART.
- DATA_OUT  out  8  to the UART's DATA_IN.
- DATA_IN  in  8  from the UART's DATA_OUT.
- Tx_RDY  in  1  from UART.
- Rx_RDY  in  1  from UART.

Behaviour:
- Reset (n_RST low, takes effect asynchronously):
  - n_CS=1, n_RD=1, n_WR=1, C_nD=1, DATA_OUT=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0; state=IDLE.
- cmd_ready = (state==IDLE) and not in reset. It is high in the first clock after reset release.
- Command acceptance: a command is accepted on the edge where cmd_valid and cmd_ready are both high. cmd_write, cmd_cd, cmd_wait and cmd_wdata are registered at that edge.
- States: IDLE, WAIT_RDY, SETUP, STROBE, HOLD, RESP.
- IDLE → WAIT_RDY when the accepted command has cmd_wait=1 and cmd_cd=0; otherwise IDLE → SETUP.
- WAIT_RDY:
  - Watched flag is Tx_RDY for a write, Rx_RDY for a read.
  - Flag sampled 1 → SETUP in the next cycle.
  - TIMEOUT_CYC cycles elapse without the flag → RESP with rsp_err=1. No strobe is issued.
  - n_CS stays 1 throughout WAIT_RDY.
- SETUP (SETUP_CYC cycles):
  - n_CS=0, C_nD=cmd_cd, DATA_OUT=wdata for writes (0 for reads).
  - Both strobes stay high.
- STROBE (STROBE_CYC cycles): n_WR=0 for a write, n_RD=0 for a read. The other strobe stays high.
- Read capture: DATA_IN is registered into rsp_rdata on the last STROBE cycle, i.e. the edge at which the strobe rises.
- HOLD (HOLD_CYC cycles): strobe high; n_CS, C_nD and DATA_OUT unchanged.
- RESP (exactly 1 cycle):
  - n_CS=1, rsp_valid=1, cmd_ready=0; then → IDLE.
  - Guarantees n_CS is high for at least one cycle between consecutive transactions.
- Bus outputs are driven from registers only; no combinational path from DATA_IN or cmd_* to bus outputs.
- n_RD and n_WR are never low together, and are never low while n_CS=1.
- Latency: for an accept at edge k with no wait, rsp_valid is high during cycle k+1+SETUP_CYC+STROBE_CYC+HOLD_CYC. With defaults, the response is 5 cycles after acceptance.
- A single down-counter of width $clog2(max(all parameters))+1 times every state. It reloads on each state entry.
- rsp_rdata holds its value until the next read completes. A write response presents rsp_rdata=0.
- cmd_valid while busy: ignored (cmd_ready=0). The upstream source must hold the command.
- Reset mid-transaction: strobes and n_CS go high immediately. The transaction is dropped and no rsp_valid is produced.
- Control/status cycles (cmd_cd=1) never wait, even when cmd_wait=1.

Decomposition:
- Shared package (uart_pkg) holds:
  - state enum;
  - constants C_DATA=1'b0 and C_CTRL=1'b1;
  - default timing constants.
- Optional sub-module uart_cpu_timer: loadable down-counter with a zero flag. Otherwise the block is a single FSM module.

Test Plan:
- Write control, cmd_cd=1, wdata=8'h4E, defaults:
  - n_CS falls 1 cycle after accept; n_WR low for exactly 2 cycles; DATA_OUT=8'h4E and C_nD=1 throughout the n_CS-low window.
  - rsp_valid at accept+5, rsp_err=0.
- Read status, cmd_cd=1, UART model drives DATA_IN=8'h05 → n_RD low for 2 cycles, rsp_rdata=8'h05 at rsp_valid.
- Waited data write, cmd_wait=1, wdata=8'hA5, Tx_RDY held 0 for 10 cycles then 1 → no strobe during the wait; n_WR pulse follows, DATA_OUT=8'hA5, rsp_err=0.
- Waited read with Rx_RDY stuck 0, TIMEOUT_CYC=16 → rsp_valid with rsp_err=1 after 16 wait cycles; n_RD and n_CS never asserted.
- Loopback through the UART with TxD tied to RxD:
  - program control word, write data 8'h3C, then waited data read → rsp_rdata=8'h3C;
  - back-to-back commands show n_CS high for ≥1 cycle between them.
- Assert n_RST during STROBE of a write → n_WR and n_CS read 1 in the same cycle, no rsp_valid, cmd_ready=1 one cycle after release.
